// File: rtl/hazard_ctrl_v2.sv
// Hazard, stall and flush controller for the 5-stage F/D/E/M/W pipeline.
// Forwarding and load-use/branch interlocks are combinational; divide, bus waits and exceptions run through a small FSM.
module hazard_ctrl_v2 #(
  parameter int REG_AW = 5,
  parameter int DIV_EN = 1,
  parameter int EXC_EN = 1,
  parameter int WDOG_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              div_startE,
  input  logic              div_readyE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              write_hiloM,
  input  logic              exceptM,
  input  logic              inst_req,
  input  logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_data_ok,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              forward_hilo_E,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_cancel,
  output logic              flush_pending,
  output logic              mem_timeout,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, DIV_WAIT = 2'b10} state_t;

  localparam logic DIV_ON = (DIV_EN != 0);
  localparam logic EXC_ON = (EXC_EN != 0);
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  state_t            state;
  logic              div_active;
  logic [WDOG_W-1:0] wdog;
  logic              mem_busy, exc_fire, lwstall, brstall, div_inflight;

  function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst,
                               input logic wr);
    return (src != '0) && (src == dst) && wr;
  endfunction

  assign forwardaD      = hit(rsD, writeregM, regwriteM);
  assign forwardbD      = hit(rtD, writeregM, regwriteM);
  assign forwardaE      = hit(rsE, writeregM, regwriteM) ? 2'b10 :
                          hit(rsE, writeregW, regwriteW) ? 2'b01 : 2'b00;
  assign forwardbE      = hit(rtE, writeregM, regwriteM) ? 2'b10 :
                          hit(rtE, writeregW, regwriteW) ? 2'b01 : 2'b00;
  assign forward_hilo_E = write_hiloM;

  assign lwstall = memtoregE && (rtE == rsD || rtE == rtD);
  assign brstall = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                               (memtoregM && (writeregM == rsD || writeregM == rtD)));

  // A bus request stays asserted until its data_ok; a request without data_ok this cycle is outstanding.
  assign mem_busy     = (inst_req && !inst_data_ok) || (data_req && !data_data_ok);
  assign exc_fire     = EXC_ON && (exceptM || flush_pending) && !mem_busy;
  assign div_inflight = DIV_ON && (state == DIV_WAIT || div_active || div_startE) && !div_readyE;
  assign state_o      = state;

  always_comb begin
    {stallF, stallD, stallE, stallM, stallW} = '0;
    {flushF, flushD, flushE, flushM, flushW} = '0;
    div_cancel = 1'b0;
    if (exc_fire) begin
      {flushF, flushD, flushE, flushM} = '1;
      div_cancel = (state == DIV_WAIT);
    end else if (mem_busy) begin
      {stallF, stallD, stallE, stallM} = '1;
      flushW = 1'b1;
    end else if (state == DIV_WAIT && !div_readyE) begin
      {stallF, stallD, stallE} = '1;
      flushM = 1'b1;
    end else if (lwstall || brstall) begin
      {stallF, stallD} = '1;
      flushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= RUN;
      flush_pending <= 1'b0;
      mem_timeout   <= 1'b0;
      div_active    <= 1'b0;
      wdog          <= '0;
    end else begin
      // The counter only survives while the bus keeps the FSM in MEM_WAIT.
      if (state == MEM_WAIT) begin
        if (wdog >= WDOG_MAX - 1'b1) mem_timeout <= 1'b1;
        if (mem_busy && wdog != WDOG_MAX) wdog <= wdog + 1'b1;
        else if (!mem_busy) wdog <= '0;
      end else begin
        wdog <= '0;
      end

      if (exc_fire) begin
        state         <= RUN;
        flush_pending <= 1'b0;
        div_active    <= 1'b0;
      end else if (mem_busy) begin
        state      <= MEM_WAIT;
        div_active <= div_inflight;
        if (EXC_ON && exceptM) flush_pending <= 1'b1;
      end else begin
        div_active <= 1'b0;
        case (state)
          RUN:      if (DIV_ON && div_startE) state <= DIV_WAIT;
          MEM_WAIT: state <= div_inflight ? DIV_WAIT : RUN;
          DIV_WAIT: if (div_readyE) state <= RUN;
          default:  state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Randomised plus directed bench for hazard_ctrl_v2 against a behavioural pipeline-control model.
module tb_hazard_ctrl_v2;

  localparam int WDOG_W = 3;

  typedef struct packed {
    logic [4:0] rsD, rtD;
    logic       branchD;
    logic [4:0] rsE, rtE, writeregE;
    logic       regwriteE, memtoregE, div_startE, div_readyE;
    logic [4:0] writeregM;
    logic       regwriteM, memtoregM, write_hiloM, exceptM;
    logic       inst_req, inst_data_ok, data_req, data_data_ok;
    logic [4:0] writeregW;
    logic       regwriteW;
  } stim_t;

  logic       clk, resetn;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, regwriteE, memtoregE, div_startE, div_readyE;
  logic       regwriteM, memtoregM, write_hiloM, exceptM;
  logic       inst_req, inst_data_ok, data_req, data_data_ok, regwriteW;
  logic       forwardaD, forwardbD, forward_hilo_E;
  logic [1:0] forwardaE, forwardbE, state_o;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic       div_cancel, flush_pending, mem_timeout;

  hazard_ctrl_v2 #(.REG_AW(5), .DIV_EN(1), .EXC_EN(1), .WDOG_W(WDOG_W)) dut (
    .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .div_startE(div_startE), .div_readyE(div_readyE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .write_hiloM(write_hiloM), .exceptM(exceptM),
    .inst_req(inst_req), .inst_data_ok(inst_data_ok), .data_req(data_req),
    .data_data_ok(data_data_ok), .writeregW(writeregW), .regwriteW(regwriteW),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .forward_hilo_E(forward_hilo_E), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .stallW(stallW), .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .flushW(flushW), .div_cancel(div_cancel), .flush_pending(flush_pending),
    .mem_timeout(mem_timeout), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [21:0] exp_q[$];
  stim_t       cur;

  // reference model: mode 0 = running, 1 = waiting on a bus, 2 = waiting on divide
  logic [1:0] m_mode;
  logic       m_pend, m_tmo, m_div;
  int         m_wait;

  function automatic logic fwd_hit(input logic [4:0] src, input logic [4:0] dst, input logic wr);
    return wr && src != 5'd0 && src == dst;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] src, input stim_t s);
    if (fwd_hit(src, s.writeregM, s.regwriteM)) return 2'b10;
    if (fwd_hit(src, s.writeregW, s.regwriteW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic busy_of(input stim_t s);
    return (s.inst_req && !s.inst_data_ok) || (s.data_req && !s.data_data_ok);
  endfunction

  function automatic logic [21:0] model_out(input stim_t s);
    logic       busy, fire, lw, br, dc;
    logic [4:0] st, fl;
    busy = busy_of(s);
    fire = (s.exceptM || m_pend) && !busy;
    lw = s.memtoregE && (s.rtE == s.rsD || s.rtE == s.rtD);
    br = s.branchD && ((s.regwriteE && (s.writeregE == s.rsD || s.writeregE == s.rtD)) ||
                       (s.memtoregM && (s.writeregM == s.rsD || s.writeregM == s.rtD)));
    st = 5'b0; fl = 5'b0; dc = 1'b0;
    if (fire)                            begin fl = 5'b11110; dc = (m_mode == 2'd2); end
    else if (busy)                       begin st = 5'b11110; fl = 5'b00001; end
    else if (m_mode == 2'd2 && !s.div_readyE) begin st = 5'b11100; fl = 5'b00010; end
    else if (lw || br)                   begin st = 5'b11000; fl = 5'b00100; end
    return {fwd_hit(s.rsD, s.writeregM, s.regwriteM), fwd_hit(s.rtD, s.writeregM, s.regwriteM),
            fwd_e(s.rsE, s), fwd_e(s.rtE, s), s.write_hiloM, st, fl, dc, m_pend, m_tmo, m_mode};
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_pend = 1'b0; m_tmo = 1'b0; m_div = 1'b0; m_wait = 0;
  endtask

  task automatic model_edge(input stim_t s);
    logic       busy, fire, div_left;
    logic [1:0] nxt;
    busy = busy_of(s);
    fire = (s.exceptM || m_pend) && !busy;
    if (m_mode == 2'd1) begin
      m_wait++;
      if (m_wait >= (1 << WDOG_W) - 1) m_tmo = 1'b1;
    end
    div_left = (m_div || m_mode == 2'd2 || s.div_startE) && !s.div_readyE;
    if (fire) begin
      nxt = 2'd0; m_pend = 1'b0; m_div = 1'b0;
    end else if (busy) begin
      nxt = 2'd1; m_div = div_left;
      if (s.exceptM) m_pend = 1'b1;
    end else begin
      case (m_mode)
        2'd0:    nxt = s.div_startE ? 2'd2 : 2'd0;
        2'd1:    nxt = div_left ? 2'd2 : 2'd0;
        default: nxt = s.div_readyE ? 2'd0 : 2'd2;
      endcase
      m_div = 1'b0;
    end
    if (nxt != 2'd1) m_wait = 0;
    m_mode = nxt;
  endtask

  // driver: one call per clock cycle
  task automatic drive(input stim_t s, input logic rst_low);
    @(posedge clk);
    #1;
    if (resetn) model_edge(cur);
    cur = s;
    rsD = s.rsD; rtD = s.rtD; branchD = s.branchD;
    rsE = s.rsE; rtE = s.rtE; writeregE = s.writeregE;
    regwriteE = s.regwriteE; memtoregE = s.memtoregE;
    div_startE = s.div_startE; div_readyE = s.div_readyE;
    writeregM = s.writeregM; regwriteM = s.regwriteM; memtoregM = s.memtoregM;
    write_hiloM = s.write_hiloM; exceptM = s.exceptM;
    inst_req = s.inst_req; inst_data_ok = s.inst_data_ok;
    data_req = s.data_req; data_data_ok = s.data_data_ok;
    writeregW = s.writeregW; regwriteW = s.regwriteW;
    if (rst_low) begin
      resetn = 1'b0;
      model_reset();
    end else begin
      resetn = 1'b1;
    end
    exp_q.push_back(model_out(s));
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
    s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
    s.writeregE = 5'($urandom_range(0, 3)); s.writeregM = 5'($urandom_range(0, 3));
    s.writeregW = 5'($urandom_range(0, 3));
    s.branchD = ($urandom_range(0, 4) == 0);
    s.regwriteE = $urandom_range(0, 1); s.memtoregE = ($urandom_range(0, 4) == 0);
    s.regwriteM = $urandom_range(0, 1); s.memtoregM = ($urandom_range(0, 4) == 0);
    s.regwriteW = $urandom_range(0, 1); s.write_hiloM = ($urandom_range(0, 5) == 0);
    s.div_startE = ($urandom_range(0, 29) == 0);
    s.div_readyE = !s.div_startE && ($urandom_range(0, 9) == 0);
    s.exceptM = ($urandom_range(0, 24) == 0);
    s.inst_req = ($urandom_range(0, 5) == 0); s.inst_data_ok = $urandom_range(0, 1);
    s.data_req = ($urandom_range(0, 5) == 0); s.data_data_ok = $urandom_range(0, 1);
    return s;
  endfunction

  // scoreboard monitor
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  logic [21:0] dut_vec;
  assign dut_vec = {forwardaD, forwardbD, forwardaE, forwardbE, forward_hilo_E,
                    stallF, stallD, stallE, stallM, stallW,
                    flushF, flushD, flushE, flushM, flushW,
                    div_cancel, flush_pending, mem_timeout, state_o};

  always begin
    logic [21:0] e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("forwarding",  16'(dut_vec[21:15]), 16'(e[21:15]));
      check("stall_flush", 16'(dut_vec[14:5]),  16'(e[14:5]));
      check("fsm_flags",   16'(dut_vec[4:0]),   16'(e[4:0]));
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL time_limit at %0t: got no completion expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    stim_t s;
    resetn = 1'b0;
    cur = idle();
    model_reset();
    drive(idle(), 1'b1);
    repeat (3) drive(idle(), 1'b0);

    // load-use then W forwarding
    s = idle(); s.memtoregE = 1'b1; s.rtE = 5'd2; s.rsD = 5'd2; s.rtD = 5'd7;
    drive(s, 1'b0);
    s = idle(); s.rsE = 5'd2; s.regwriteW = 1'b1; s.writeregW = 5'd2;
    drive(s, 1'b0);
    // M over W priority, then register 0
    s = idle(); s.rsE = 5'd5; s.rtE = 5'd5; s.regwriteM = 1'b1; s.writeregM = 5'd5;
    s.regwriteW = 1'b1; s.writeregW = 5'd5;
    drive(s, 1'b0);
    s.rsE = 5'd0; s.rtE = 5'd0; s.writeregM = 5'd0; s.writeregW = 5'd0;
    drive(s, 1'b0);

    // 33-cycle divide with zero-latency release
    s = idle(); s.div_startE = 1'b1;
    drive(s, 1'b0);
    repeat (33) drive(idle(), 1'b0);
    s = idle(); s.div_readyE = 1'b1;
    drive(s, 1'b0);
    drive(idle(), 1'b0);

    // exception deferred behind a data bus wait
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.data_req = 1'b1; s.exceptM = (i == 1);
      drive(s, 1'b0);
    end
    s = idle(); s.data_req = 1'b1; s.data_data_ok = 1'b1;
    drive(s, 1'b0);
    repeat (2) drive(idle(), 1'b0);

    // exception during divide wait, with ready in the same cycle
    s = idle(); s.div_startE = 1'b1;
    drive(s, 1'b0);
    repeat (4) drive(idle(), 1'b0);
    s = idle(); s.exceptM = 1'b1; s.div_readyE = 1'b1;
    drive(s, 1'b0);
    repeat (2) drive(idle(), 1'b0);

    // watchdog expiry on a stuck fetch, sticky until reset
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.inst_req = 1'b1;
      drive(s, 1'b0);
    end
    s = idle(); s.inst_req = 1'b1; s.inst_data_ok = 1'b1;
    drive(s, 1'b0);
    repeat (3) drive(idle(), 1'b0);
    drive(idle(), 1'b1);
    drive(idle(), 1'b0);

    // reset in the middle of a bus stall
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.data_req = 1'b1; s.exceptM = (i == 1);
      drive(s, 1'b0);
    end
    drive(idle(), 1'b1);
    repeat (2) drive(idle(), 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) drive(idle(), 1'b1);
      else drive(rand_stim(), 1'b0);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
